// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl : flush/lock sequencer for the IF/ID..MEM/WB registers
// and the PC (load-use, taken branch, data-memory wait, timeout).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_lock,
  output logic             o_lock_id,
  output logic             o_lock_ex,
  output logic             o_lock_mem,
  output logic             o_lock_wb,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_flush_mem,
  output logic             o_flush_wb,
  output logic             o_err_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] c_wait_last = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_TIMEOUT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WCNT_W-1:0]  r_wait_cnt;
  logic               r_err_timeout;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic [CNT_W-1:0]   r_flush_events;

  logic w_mem_stall;
  logic w_load_use;
  logic w_branch_apply;

  always_comb begin
    w_mem_stall = ((r_state == S_RUN) && i_mem_req && !i_mem_ready) ||
                  ((r_state == S_MEM_WAIT) && !i_mem_ready);
    w_load_use  = i_ex_memread && (i_ex_rd != 5'd0) &&
                  ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                   (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));
  end

  // Priority: reset > timeout > memory stall > taken branch > load-use.
  always_comb begin
    o_pc_lock      = 1'b0;
    o_lock_id      = 1'b0;
    o_lock_ex      = 1'b0;
    o_lock_mem     = 1'b0;
    o_lock_wb      = 1'b0;
    o_flush_id     = 1'b0;
    o_flush_ex     = 1'b0;
    o_flush_mem    = 1'b0;
    o_flush_wb     = 1'b0;
    w_branch_apply = 1'b0;
    if (rst) begin
      o_flush_id  = 1'b1;
      o_flush_ex  = 1'b1;
      o_flush_mem = 1'b1;
      o_flush_wb  = 1'b1;
    end else if (r_state == S_TIMEOUT) begin
      o_pc_lock  = 1'b1;
      o_lock_id  = 1'b1;
      o_lock_ex  = 1'b1;
      o_lock_mem = 1'b1;
      o_lock_wb  = 1'b1;
    end else if (w_mem_stall) begin
      o_pc_lock  = 1'b1;
      o_lock_id  = 1'b1;
      o_lock_ex  = 1'b1;
      o_lock_mem = 1'b1;
      o_flush_wb = 1'b1;
    end else if (i_ex_branch_taken) begin
      o_flush_id     = 1'b1;
      o_flush_ex     = 1'b1;
      w_branch_apply = 1'b1;
    end else if (w_load_use) begin
      o_pc_lock  = 1'b1;
      o_lock_id  = 1'b1;
      o_flush_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_wait_cnt     <= '0;
      r_err_timeout  <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_wait_cnt <= '0;
          if (i_mem_req && !i_mem_ready) begin
            r_state <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (i_mem_ready) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == c_wait_last) begin
            r_state       <= S_TIMEOUT;
            r_err_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          end
        end
        S_TIMEOUT: begin
          r_state <= S_TIMEOUT;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
      if (o_pc_lock && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_branch_apply && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
    end
  end

  assign o_err_timeout  = r_err_timeout;
  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_events = r_flush_events;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl : directed literal checks plus randomized stimulus
// compared every cycle against a behavioural model.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 6;
  localparam int SAT         = (1 << CNT_W) - 1;

  // flag vector order: {pc, lock_id, lock_ex, lock_mem, lock_wb, fl_id, fl_ex, fl_mem, fl_wb}
  localparam logic [8:0] F_NONE  = 9'b000000000;
  localparam logic [8:0] F_RESET = 9'b000001111;
  localparam logic [8:0] F_LU    = 9'b110000100;
  localparam logic [8:0] F_MEM   = 9'b111100001;
  localparam logic [8:0] F_BR    = 9'b000001100;
  localparam logic [8:0] F_TO    = 9'b111110000;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic pc_lock, lock_id, lock_ex, lock_mem, lock_wb;
  logic flush_id, flush_ex, flush_mem, flush_wb, err_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_id_rs1         (id_rs1),
    .i_id_rs2         (id_rs2),
    .i_id_use_rs1     (id_use_rs1),
    .i_id_use_rs2     (id_use_rs2),
    .i_ex_memread     (ex_memread),
    .i_ex_rd          (ex_rd),
    .i_ex_branch_taken(ex_branch_taken),
    .i_mem_req        (mem_req),
    .i_mem_ready      (mem_ready),
    .o_pc_lock        (pc_lock),
    .o_lock_id        (lock_id),
    .o_lock_ex        (lock_ex),
    .o_lock_mem       (lock_mem),
    .o_lock_wb        (lock_wb),
    .o_flush_id       (flush_id),
    .o_flush_ex       (flush_ex),
    .o_flush_mem      (flush_mem),
    .o_flush_wb       (flush_wb),
    .o_err_timeout    (err_timeout),
    .o_stall_cycles   (stall_cycles),
    .o_flush_events   (flush_events)
  );

  wire [8:0] w_flags = {pc_lock, lock_id, lock_ex, lock_mem, lock_wb,
                        flush_id, flush_ex, flush_mem, flush_wb};

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Model state: length of the current run of memory-stalled cycles.
  int  m_run   = 0;
  bit  m_to    = 1'b0;
  int  m_stall = 0;
  int  m_flush = 0;
  bit  m_valid = 1'b0;
  logic [9:0] m_o;

  function automatic logic [9:0] model_out();
    logic lu;
    logic stall;
    lu = ex_memread && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    stall = !mem_ready && (m_run > 0 || mem_req);
    if (rst)                  return {1'b0, F_RESET};
    else if (m_to)            return {1'b0, F_TO};
    else if (stall)           return {1'b0, F_MEM};
    else if (ex_branch_taken) return {1'b1, F_BR};
    else if (lu)              return {1'b0, F_LU};
    else                      return {1'b0, F_NONE};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      m_o = model_out();
      chk("flags", {23'd0, w_flags}, {23'd0, m_o[8:0]});
      chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_to});
      chk("stall_cycles", {26'd0, stall_cycles}, m_stall);
      chk("flush_events", {26'd0, flush_events}, m_flush);
    end
  end

  always @(posedge clk) begin
    m_o = model_out();
    if (rst) begin
      m_run = 0; m_to = 1'b0; m_stall = 0; m_flush = 0; m_valid = 1'b1;
    end else begin
      if (m_o[8] && m_stall < SAT) m_stall++;
      if (m_o[9] && m_flush < SAT) m_flush++;
      if (!m_to) begin
        if (m_o[0]) begin
          m_run++;
          if (m_run > MEM_TIMEOUT) m_to = 1'b1;
        end else begin
          m_run = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_memread = 0; ex_rd = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int ready_pct;

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("reset_flags", {23'd0, w_flags}, {23'd0, F_RESET});
    rst = 1'b0;
    #2;
    chk("post_reset_flags", {23'd0, w_flags}, {23'd0, F_NONE});
    chk("post_reset_cnt", {20'd0, stall_cycles, flush_events}, 32'd0);

    // load-use on rs2
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 1; id_use_rs1 = 1;
    #2 chk("lu_flags", {23'd0, w_flags}, {23'd0, F_LU});
    tick();
    ex_memread = 0;
    #2 chk("lu_stall_cnt", {26'd0, stall_cycles}, 32'd1);
    chk("lu_after_flags", {23'd0, w_flags}, {23'd0, F_NONE});

    // load to x0 never stalls
    ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    #2 chk("lu_x0_flags", {23'd0, w_flags}, {23'd0, F_NONE});
    tick();

    // three-cycle memory wait
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("memwait_flags", {23'd0, w_flags}, {23'd0, F_MEM});
      tick();
    end
    mem_ready = 1;
    #2 chk("memwait_release", {23'd0, w_flags}, {23'd0, F_NONE});
    tick();
    mem_req = 0; mem_ready = 0;
    #2 chk("memwait_stall_cnt", {26'd0, stall_cycles}, 32'd3);

    // branch held during a two-cycle wait
    do_reset();
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    #2 chk("br_wait1", {23'd0, w_flags}, {23'd0, F_MEM});
    tick();
    #2 chk("br_wait2", {23'd0, w_flags}, {23'd0, F_MEM});
    tick();
    mem_ready = 1;
    #2 chk("br_release", {23'd0, w_flags}, {23'd0, F_BR});
    tick();
    idle();
    #2 chk("br_flush_cnt", {26'd0, flush_events}, 32'd1);

    // branch beats load-use
    do_reset();
    ex_branch_taken = 1; ex_memread = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    #2 chk("br_lu_flags", {23'd0, w_flags}, {23'd0, F_BR});
    tick();

    // timeout and recovery
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (5) tick();
    #2 chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_flags", {23'd0, w_flags}, {23'd0, F_TO});
    chk("to_stall_cnt", {26'd0, stall_cycles}, 32'd5);
    mem_ready = 1; ex_branch_taken = 1;
    #2 chk("to_sticky_flags", {23'd0, w_flags}, {23'd0, F_TO});
    rst = 1;
    #2 chk("to_rst_flags", {23'd0, w_flags}, {23'd0, F_RESET});
    tick();
    rst = 0; idle();
    #2 chk("to_rst_err", {31'd0, err_timeout}, 32'd0);
    chk("to_rst_out", {23'd0, w_flags}, {23'd0, F_NONE});

    // randomized phase
    ready_pct = 60;
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) ready_pct = 30 * $urandom_range(1, 3);
      rst             = ($urandom_range(0, 199) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_use_rs1      = $urandom_range(0, 1) == 1;
      id_use_rs2      = $urandom_range(0, 1) == 1;
      ex_memread      = $urandom_range(0, 2) == 0;
      ex_branch_taken = $urandom_range(0, 4) == 0;
      mem_req         = $urandom_range(0, 2) == 0;
      mem_ready       = $urandom_range(0, 99) < ready_pct;
      tick();
    end
    idle();
    rst = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
